data_read: RTL and testbench
============================

# data_read

Read-data responder of the AXI memory slave. It takes one accepted read command (address, ID, length, size, burst type) from the read-address stage and reads the burst beat by beat from the slave's synchronous memory. It returns each beat on the AXI R channel with correct RID, RRESP and RLAST, honouring RREADY backpressure, and sits between the read-address stage's command output and the external R-channel pins.

## Interface
Parameters (defaults; widths come from the shared `param.v` header):
- ADD_ID_WIDTH, 4: transaction ID width
- ADD_WIDTH, 32: byte address width
- BURST_LEN, 4: ARLEN width (AXI3, up to 16 beats)
- BURST_SIZE, 3: ARSIZE width
- BURST_TYPE, 2: ARBURST width
- DATA_WIDTH, 32: R-channel data width in bits (power of two, 8 to 1024)
- MEM_ADDR_WIDTH, 10: memory word-address width

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- cmd_valid_in  in  1  command from read-address stage is valid
- cmd_ready_out  out  1  block can accept a command
- addr_in  in  ADD_WIDTH  burst start byte address
- id_in  in  ADD_ID_WIDTH  transaction ID
- len_in  in  BURST_LEN  beats minus one
- size_in  in  BURST_SIZE  log2 of bytes per beat
- burst_in  in  BURST_TYPE  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  MEM_ADDR_WIDTH  memory word address
- mem_rd_data  in  DATA_WIDTH  read data; valid the cycle after mem_rd_en, held until the next mem_rd_en
- rid  out  ADD_ID_WIDTH  latched ID
- rdata  out  DATA_WIDTH  beat data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rlast  out  1  final beat of the burst
- rvalid  out  1  beat valid
- rready  in  1  master accepts the beat

## Operation
- States are IDLE, FETCH and SEND.
- In IDLE, cmd_ready_out=1.
- A command is accepted on an edge where cmd_valid_in and cmd_ready_out are both high. On acceptance the block latches addr, id, len, size and burst, clears the beat counter, sets the error flag and moves to FETCH.
- Error flag is set when burst_in==3, when size_in > log2(DATA_WIDTH/8), or when burst_in is WRAP and len_in is not 1, 3, 7 or 15.
- FETCH:
  - mem_rd_en=1 unless the error flag is set.
  - mem_rd_addr = cur_addr[log2(DATA_WIDTH/8) +: MEM_ADDR_WIDTH]. Out-of-range addresses alias by truncation.
  - Next state is always SEND.
- SEND:
  - rvalid=1.
  - rdata = mem_rd_data, or 0 on error.
  - rresp = SLVERR if the error flag is set, else OKAY.
  - rlast = (beat count == latched len).
  - On an edge with rvalid and rready both high: if rlast, go to IDLE. Otherwise increment the beat count, advance cur_addr, and go to FETCH.
  - Without rready, every R output stays stable.
- Address advance uses bytes = 1<<size and aligned = cur_addr with the low size bits cleared:
  - FIXED: cur_addr is unchanged.
  - INCR: next = aligned + bytes. An unaligned start applies only to the first beat.
  - WRAP: total = bytes*(len+1) and base = cur_addr with the low log2(total) bits cleared. next = aligned + bytes; if next == base + total, next = base.
  - Arithmetic is ADD_WIDTH-wide and wraps modulo 2^ADD_WIDTH. There is no 4 KB boundary check.
- An error burst still returns exactly len+1 beats, all SLVERR, with no memory access.
- Reset while a burst is in progress abandons the burst. State returns to IDLE and no further beats are issued.

## Timing
- Reset values: rvalid=0, rlast=0, rresp=0, rid=0, mem_rd_en=0, mem_rd_addr=0, rdata=0. cmd_ready_out=0 while reset is high, and 1 in the first cycle after reset is released.
- cmd_ready_out is decoded from state only, with no path from cmd_valid_in. This avoids a combinational loop with the read-address stage, whose valid depends on ready.
- Latency: command accepted at edge T0 gives FETCH in cycle 1 and rvalid high in cycle 2.
- Throughput: one beat per two cycles with rready held high. An N-beat burst occupies 2N cycles plus the cycle back in IDLE.
- Once asserted, rvalid is never withdrawn before the handshake. rid, rdata, rresp and rlast change only after a handshake.
- Back-to-back commands: the next command is accepted only in the IDLE cycle following the last beat's handshake.

## Structure
- Shared `param.v` header holds:
  - the width parameters
  - burst codes BURST_FIXED=0, BURST_INCR=1, BURST_WRAP=2
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- One combinational sub-module, burst_addr_gen: inputs cur_addr, size, len, burst; output next_addr. It is reused by the planned write-data stage.

## Test plan
- INCR, addr 0x10, len 3, size 2, rready=1 -> mem_rd_addr 4,5,6,7; four beats with rresp 0; rlast only on the 4th; first rvalid 2 cycles after acceptance.
- WRAP, addr 0x38, len 3, size 2 -> byte addresses 0x38, 0x3C, 0x30, 0x34 (mem_rd_addr 14,15,12,13).
- FIXED, addr 0x20, len 2, plus random rready stalls -> three reads of word 8; rdata, rid and rlast stay stable during stalls.
- burst_in=3, len 1 -> two beats with rresp 2'b10 and rdata 0; mem_rd_en never asserted.
- Unaligned INCR, addr 0x03, size 2, len 1 -> word addresses 0 then 1.
- Reset asserted during beat 2 of a 4-beat burst -> rvalid 0 on the next cycle, cmd_ready_out 1 after release, a new command is served normally with rid from the new command.

Source files
------------

// File: rtl/data_read_pkg.sv
// Shared definitions for the AXI slave read path: burst/response codes and FSM states.
package data_read_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND
  } rd_state_t;

  // A wrapping burst must span 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts; shared with the write path.
module burst_addr_gen
  import data_read_pkg::*;
#(
  parameter int ADD_WIDTH  = 32,
  parameter int BURST_LEN  = 4,
  parameter int BURST_SIZE = 3,
  parameter int BURST_TYPE = 2
) (
  input  logic [ADD_WIDTH-1:0]  cur_addr,
  input  logic [BURST_SIZE-1:0] size,
  input  logic [BURST_LEN-1:0]  len,
  input  logic [BURST_TYPE-1:0] burst,
  output logic [ADD_WIDTH-1:0]  next_addr
);

  localparam logic [ADD_WIDTH-1:0] ONE = ADD_WIDTH'(1);

  logic [ADD_WIDTH-1:0] bytes;
  logic [ADD_WIDTH-1:0] aligned;
  logic [ADD_WIDTH-1:0] total;
  logic [ADD_WIDTH-1:0] base;
  logic [ADD_WIDTH-1:0] incr;

  // NOTE: every output of a combinational block gets a default on every path, so no latch is inferred.
  always_comb begin
    bytes     = ONE << size;
    aligned   = cur_addr & ~(bytes - ONE);
    total     = bytes * (ADD_WIDTH'(len) + ONE);
    base      = cur_addr & ~(total - ONE);
    incr      = aligned + bytes;
    next_addr = incr;
    if (burst == BURST_TYPE'(BURST_FIXED)) begin
      next_addr = cur_addr;
    end else if (burst == BURST_TYPE'(BURST_WRAP)) begin
      next_addr = (incr == base + total) ? base : incr;
    end
  end

endmodule

// File: rtl/data_read.sv
// AXI R-channel responder: fetches each burst beat from synchronous memory and returns it with RID/RRESP/RLAST.
module data_read
  import data_read_pkg::*;
#(
  parameter int ADD_ID_WIDTH   = 4,
  parameter int ADD_WIDTH      = 32,
  parameter int BURST_LEN      = 4,
  parameter int BURST_SIZE     = 3,
  parameter int BURST_TYPE     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [ADD_WIDTH-1:0]      addr_in,
  input  logic [ADD_ID_WIDTH-1:0]   id_in,
  input  logic [BURST_LEN-1:0]      len_in,
  input  logic [BURST_SIZE-1:0]     size_in,
  input  logic [BURST_TYPE-1:0]     burst_in,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [ADD_ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);

  rd_state_t             state;
  logic [ADD_WIDTH-1:0]  cur_addr;
  logic [ADD_WIDTH-1:0]  next_addr;
  logic [BURST_LEN-1:0]  len_q;
  logic [BURST_LEN-1:0]  beat;
  logic [BURST_SIZE-1:0] size_q;
  logic [BURST_TYPE-1:0] burst_q;
  logic                  err_q;
  logic                  cmd_err;

  always_comb begin
    cmd_err = 1'b0;
    if (burst_in == BURST_TYPE'(BURST_RSVD)) cmd_err = 1'b1;
    if (int'(size_in) > LANE_BITS) cmd_err = 1'b1;
    if (burst_in == BURST_TYPE'(BURST_WRAP) && !wrap_len_ok(int'(len_in))) cmd_err = 1'b1;
  end

  burst_addr_gen #(
    .ADD_WIDTH (ADD_WIDTH),
    .BURST_LEN (BURST_LEN),
    .BURST_SIZE(BURST_SIZE),
    .BURST_TYPE(BURST_TYPE)
  ) u_addr_gen (
    .cur_addr (cur_addr),
    .size     (size_q),
    .len      (len_q),
    .burst    (burst_q),
    .next_addr(next_addr)
  );

  // Ready depends on state only, never on cmd_valid_in, to keep the address stage loop-free.
  assign cmd_ready_out = (state == ST_IDLE) && !reset;

  // Memory holds its output until the next read strobe, so rdata is stable through stalls.
  assign rdata = (state == ST_SEND && !err_q) ? mem_rd_data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      len_q       <= '0;
      beat        <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      rid         <= '0;
      rresp       <= RESP_OKAY;
      rlast       <= 1'b0;
      rvalid      <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            cur_addr    <= addr_in;
            rid         <= id_in;
            len_q       <= len_in;
            size_q      <= size_in;
            burst_q     <= burst_in;
            beat        <= '0;
            err_q       <= cmd_err;
            mem_rd_en   <= !cmd_err;
            mem_rd_addr <= addr_in[LANE_BITS +: MEM_ADDR_WIDTH];
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          mem_rd_en <= 1'b0;
          rvalid    <= 1'b1;
          rresp     <= err_q ? RESP_SLVERR : RESP_OKAY;
          rlast     <= (beat == len_q);
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              state <= ST_IDLE;
            end else begin
              beat        <= beat + BURST_LEN'(1);
              cur_addr    <= next_addr;
              mem_rd_en   <= !err_q;
              mem_rd_addr <= next_addr[LANE_BITS +: MEM_ADDR_WIDTH];
              state       <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_read.sv
// Self-checking bench for data_read: directed bursts plus randomized commands against a beat-list model.
module tb_data_read;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [31:0] addr_in;
  logic [3:0]  id_in;
  logic [3:0]  len_in;
  logic [2:0]  size_in;
  logic [1:0]  burst_in;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  data_read dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_in (cmd_valid_in),
    .cmd_ready_out(cmd_ready_out),
    .addr_in      (addr_in),
    .id_in        (id_in),
    .len_in       (len_in),
    .size_in      (size_in),
    .burst_in     (burst_in),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [9:0]  word;
    logic        err;
  } beat_t;

  int          n_checks = 0;
  int          n_err = 0;
  int          beats_done = 0;
  bit          rr_random = 0;
  bit          held = 0;
  logic [31:0] mem_words[1024];
  beat_t       exp_q[$];
  int          log_words[$];
  int          log_resp[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: data appears the cycle after the strobe and holds until the next strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_words[mem_rd_addr];

  always begin
    @(posedge clk);
    #1;
    rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Byte address of beat i, computed directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                            input int len, input int burst, input int i);
    logic [31:0] bytes, aligned, total, base;
    bytes   = 32'd1 << size;
    aligned = start & ~(bytes - 32'd1);
    if (i == 0 || burst == 0) return start;
    if (burst == 2) begin
      total = bytes * 32'(len + 1);
      base  = start & ~(total - 32'd1);
      return base + ((aligned - base + bytes * 32'(i)) % total);
    end
    return aligned + bytes * 32'(i);
  endfunction

  // Compare process: every fetch and every presented beat is checked against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      held = 0;
    end else begin
      if (held) check("rvalid_withdrawn", rvalid, 1);
      held = 0;
      if (mem_rd_en) begin
        log_words.push_back(int'(mem_rd_addr));
        if (exp_q.size() == 0) check("unexpected_fetch_q", exp_q.size(), 1);
        else begin
          check("mem_rd_addr", mem_rd_addr, exp_q[0].word);
          check("rd_on_error", exp_q[0].err, 0);
        end
      end
      if (rvalid) begin
        if (exp_q.size() == 0) check("unexpected_beat_q", exp_q.size(), 1);
        else begin
          check("rid", rid, exp_q[0].id);
          check("rdata", rdata, exp_q[0].data);
          check("rresp", rresp, exp_q[0].resp);
          check("rlast", rlast, exp_q[0].last);
          if (rready) begin
            log_resp.push_back(int'(rresp));
            void'(exp_q.pop_front());
            beats_done++;
          end else held = 1;
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [3:0] id, input int len,
                          input int size, input int burst);
    bit          err;
    int          waited;
    beat_t       b;
    logic [31:0] ba;
    err = (burst == 3) || (size > 2) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    waited = 0;
    while (!cmd_ready_out && waited < 400) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("cmd_ready_wait", cmd_ready_out, 1);
    for (int i = 0; i <= len; i++) begin
      ba     = beat_addr(a, size, len, burst, i);
      b.id   = id;
      b.word = ba[11:2];
      b.err  = err;
      b.data = err ? 32'd0 : mem_words[b.word];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == len);
      exp_q.push_back(b);
    end
    cmd_valid_in = 1'b1;
    addr_in      = a;
    id_in        = id;
    len_in       = 4'(len);
    size_in      = 3'(size);
    burst_in     = 2'(burst);
    @(posedge clk);
    #1;
    cmd_valid_in = 1'b0;
    @(negedge clk);
    check("lat_c1_rvalid", rvalid, 0);
    check("lat_c1_rd_en", mem_rd_en, !err);
    @(negedge clk);
    check("lat_c2_rvalid", rvalid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready_out) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_words(input string name, input int exp_w[]);
    check({name, "_count"}, log_words.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < log_words.size(); i++)
      check(name, log_words[i], exp_w[i]);
  endtask

  initial begin
    int base;
    int n;
    foreach (mem_words[i]) mem_words[i] = $urandom;
    reset        = 1'b1;
    cmd_valid_in = 1'b0;
    addr_in      = '0;
    id_in        = '0;
    len_in       = '0;
    size_in      = '0;
    burst_in     = '0;
    rready       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cmd_ready", cmd_ready_out, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready_out, 1);

    log_words.delete();
    log_resp.delete();
    send_cmd(32'h10, 4'h1, 3, 2, 1);
    wait_idle();
    check_words("incr_words", '{4, 5, 6, 7});

    log_words.delete();
    send_cmd(32'h38, 4'h2, 3, 2, 2);
    wait_idle();
    check_words("wrap_words", '{14, 15, 12, 13});

    log_words.delete();
    rr_random = 1;
    send_cmd(32'h20, 4'h3, 2, 2, 0);
    wait_idle();
    check_words("fixed_words", '{8, 8, 8});
    rr_random = 0;

    log_words.delete();
    log_resp.delete();
    send_cmd(32'h40, 4'h4, 1, 2, 3);
    wait_idle();
    check("err_rd_count", log_words.size(), 0);
    check("err_beats", log_resp.size(), 2);
    foreach (log_resp[i]) check("err_resp", log_resp[i], 2);

    log_words.delete();
    send_cmd(32'h03, 4'h6, 1, 2, 1);
    wait_idle();
    check_words("unaligned_words", '{0, 1});

    // Reset while beat 2 of a 4-beat burst is on the bus.
    base = beats_done;
    send_cmd(32'h100, 4'h5, 3, 2, 1);
    n = 0;
    while (!(beats_done == base + 1 && rvalid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat2_reached", beats_done - base, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rd_en", mem_rd_en, 0);
    check("midrst_cmd_ready", cmd_ready_out, 0);
    check("midrst_rid", rid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", cmd_ready_out, 1);
    send_cmd(32'h200, 4'h9, 2, 2, 1);
    wait_idle();

    rr_random = 1;
    for (int k = 0; k < 40; k++) begin
      send_cmd($urandom, 4'($urandom), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule
